// File: rtl/router_output_channel_pkg.sv
// Shared router definitions: port indices, VC encoding, default flit width
// and the one-hot test used by the output-side blocks.
package router_output_channel_pkg;

   localparam int PORT_PE        = 0;
   localparam int PORT_RIGHT     = 1;
   localparam int PORT_LEFT      = 2;
   localparam int PORT_DOWN      = 3;
   localparam int PORT_UP        = 4;
   localparam int NUM_PORTS      = 5;

   localparam logic VC_EVEN      = 1'b0;
   localparam logic VC_ODD       = 1'b1;

   localparam int DATA_WIDTH_DEF = 64;

   // True when exactly one bit of the grant vector is set.
   function automatic logic is_onehot5(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

endpackage

// File: rtl/router_output_channel_onehot_mux5.sv
// Combinational AND-OR 5:1 selector driven by a one-hot select; o_onehot
// reports whether the select was a legal one-hot vector.
module onehot_mux5
   import router_output_channel_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [NUM_PORTS-1:0]            i_sel,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic                            o_onehot
);

   logic [DATA_WIDTH-1:0] w_data;

   // OR together every slice masked by its select bit; no priority between inputs.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_data = w_data | (i_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{i_sel[i]}});
      end
   end

   assign o_data   = w_data;
   assign o_onehot = is_onehot5(i_sel);

endmodule

// File: rtl/router_output_channel.sv
// Two-slot (even/odd VC) output buffer between the per-output arbiter and
// the outgoing link; slot `polarity` is written, slot `~polarity` is sent.
module router_output_channel
   import router_output_channel_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            polarity,
   input  logic                            en,
   input  logic [NUM_PORTS-1:0]            gnt,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
   output logic                            output_empty,
   output logic [NUM_PORTS-1:0]            in_ack,
   output logic                            out_send,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [CNT_WIDTH-1:0]            sent_count,
   output logic                            gnt_err
);

   logic [DATA_WIDTH-1:0] r_buf [2];
   logic [1:0]            r_valid;
   logic [CNT_WIDTH-1:0]  r_sent_count;
   logic                  r_gnt_err;

   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_onehot;
   logic                  w_int_idx;
   logic                  w_ext_idx;
   logic                  w_int_valid;
   logic                  w_ext_valid;
   logic                  w_slot_free;
   logic                  w_cap;
   logic                  w_bad;
   logic                  w_send;

   onehot_mux5 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .i_sel    (gnt),
      .i_data   (in_data),
      .o_data   (w_sel_data),
      .o_onehot (w_onehot)
   );

   assign w_int_idx   = polarity;
   assign w_ext_idx   = ~polarity;
   assign w_int_valid = r_valid[w_int_idx];
   assign w_ext_valid = r_valid[w_ext_idx];

   assign w_slot_free = en & ~w_int_valid;
   assign w_cap       = w_slot_free & w_onehot;
   assign w_bad       = w_slot_free & (gnt != 5'd0) & ~w_onehot;
   assign w_send      = w_ext_valid & out_ready;

   assign output_empty = ~w_int_valid;
   assign in_ack       = w_cap ? gnt : 5'd0;
   assign out_send     = w_ext_valid;
   assign out_data     = polarity ? r_buf[VC_EVEN] : r_buf[VC_ODD];
   assign sent_count   = r_sent_count;
   assign gnt_err      = r_gnt_err;

   // Slot capture/drain, saturating link counter and sticky bad-grant flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_buf[VC_EVEN] <= '0;
         r_buf[VC_ODD]  <= '0;
         r_valid        <= 2'b00;
         r_sent_count   <= '0;
         r_gnt_err      <= 1'b0;
      end else begin
         // Capture and send address opposite slots, so both may fire together.
         if (w_cap) begin
            r_buf[w_int_idx]   <= w_sel_data;
            r_valid[w_int_idx] <= 1'b1;
         end
         if (w_send) begin
            r_valid[w_ext_idx] <= 1'b0;
            if (r_sent_count != {CNT_WIDTH{1'b1}}) begin
               r_sent_count <= r_sent_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         if (w_bad) begin
            r_gnt_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_router_output_channel.sv
// Randomized self-checking bench for router_output_channel against a
// slot-level reference model; a CNT_WIDTH=4 twin checks counter saturation.
module tb_router_output_channel;
   import router_output_channel_pkg::*;

   localparam int DW = 64;

   logic              clk;
   logic              reset;
   logic              polarity;
   logic              en;
   logic [4:0]        gnt;
   logic [5*DW-1:0]   in_data;
   logic              out_ready;

   logic              output_empty, s_output_empty;
   logic [4:0]        in_ack, s_in_ack;
   logic              out_send, s_out_send;
   logic [DW-1:0]     out_data, s_out_data;
   logic [15:0]       sent_count;
   logic [3:0]        s_sent_count;
   logic              gnt_err, s_gnt_err;

   int checks = 0;
   int errors = 0;

   bit          m_full [2];
   logic [DW-1:0] m_data [2];
   int          m_count;
   bit          m_err;

   router_output_channel #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .polarity(polarity), .en(en), .gnt(gnt),
      .in_data(in_data), .output_empty(output_empty), .in_ack(in_ack),
      .out_send(out_send), .out_ready(out_ready), .out_data(out_data),
      .sent_count(sent_count), .gnt_err(gnt_err)
   );

   router_output_channel #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .reset(reset), .polarity(polarity), .en(en), .gnt(gnt),
      .in_data(in_data), .output_empty(s_output_empty), .in_ack(s_in_ack),
      .out_send(s_out_send), .out_ready(out_ready), .out_data(s_out_data),
      .sent_count(s_sent_count), .gnt_err(s_gnt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and update the reference model from the spec rules.
   task automatic tick();
      int p, q, idx;
      bit cap, bad, snd;
      p = int'(polarity);
      q = 1 - p;
      idx = 0;
      for (int i = 0; i < 5; i++) if (gnt[i]) idx = i;
      cap = en && !m_full[p] && ($countones(gnt) == 1);
      bad = en && !m_full[p] && ($countones(gnt) > 1);
      snd = m_full[q] && out_ready;
      @(posedge clk);
      if (!reset) begin
         m_full[0] = 1'b0; m_full[1] = 1'b0;
         m_data[0] = '0;   m_data[1] = '0;
         m_count = 0; m_err = 1'b0;
      end else begin
         if (cap) begin m_full[p] = 1'b1; m_data[p] = in_data[idx*DW +: DW]; end
         if (snd) begin m_full[q] = 1'b0; m_count++; end
         if (bad) m_err = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; gnt = 5'd0; out_ready = 1'b0; en = 1'b0;
      tick(); tick();
      reset = 1'b1; en = 1'b1;
   endtask

   task automatic rand_data();
      for (int i = 0; i < 5; i++) in_data[i*DW +: DW] = {$urandom, $urandom};
   endtask

   task automatic test_reset();
      polarity = 1'b0;
      in_data = '0;
      do_reset();
      #2;
      checks++; if (output_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", output_empty); end
      checks++; if (out_send !== 1'b0) begin errors++; $display("FAIL reset_send got %b want 0", out_send); end
      checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sent_count); end
      checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", gnt_err); end
      checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
      checks++; if (in_ack !== 5'd0) begin errors++; $display("FAIL reset_ack got %b want 0", in_ack); end
   endtask

   task automatic test_basic();
      polarity = 1'b0; gnt = 5'b00100; out_ready = 1'b0;
      rand_data();
      in_data[PORT_LEFT*DW +: DW] = 64'hA5;
      #2;
      checks++; if (in_ack !== 5'b00100) begin errors++; $display("FAIL basic_ack got %b want 00100", in_ack); end
      tick();
      polarity = 1'b1; gnt = 5'd0; out_ready = 1'b1;
      #2;
      checks++; if (out_send !== 1'b1) begin errors++; $display("FAIL basic_send got %b want 1", out_send); end
      checks++; if (out_data !== 64'hA5) begin errors++; $display("FAIL basic_data got %h want a5", out_data); end
      tick();
      polarity = 1'b0; out_ready = 1'b0;
      #2;
      checks++; if (sent_count !== 16'd1) begin errors++; $display("FAIL basic_count got %0d want 1", sent_count); end
      checks++; if (output_empty !== 1'b1) begin errors++; $display("FAIL basic_cleared got %b want 1", output_empty); end
   endtask

   task automatic test_backpressure();
      logic [15:0] cnt0;
      polarity = 1'b0; out_ready = 1'b0; gnt = 5'b00001;
      in_data[PORT_PE*DW +: DW] = 64'h11;
      #2;
      checks++; if (in_ack !== 5'b00001) begin errors++; $display("FAIL bp_fill_ack got %b want 00001", in_ack); end
      tick();
      for (int k = 0; k < 6; k++) begin
         polarity = (k % 2 == 0) ? 1'b1 : 1'b0;
         gnt = polarity ? 5'd0 : 5'b00001;
         in_data[PORT_PE*DW +: DW] = 64'h22;
         #2;
         if (polarity) begin
            checks++; if (out_send !== 1'b1 || out_data !== 64'h11) begin errors++; $display("FAIL bp_hold got send=%b data=%h want 1/11", out_send, out_data); end
         end else begin
            checks++; if (output_empty !== 1'b0 || in_ack !== 5'd0) begin errors++; $display("FAIL bp_blocked got empty=%b ack=%b want 0/00000", output_empty, in_ack); end
         end
         tick();
      end
      cnt0 = sent_count;
      polarity = 1'b1; gnt = 5'd0; out_ready = 1'b1;
      #2;
      checks++; if (out_send !== 1'b1 || out_data !== 64'h11) begin errors++; $display("FAIL bp_release got send=%b data=%h want 1/11", out_send, out_data); end
      tick();
      polarity = 1'b0; #2; tick();
      polarity = 1'b1; #2;
      checks++; if (out_send !== 1'b0) begin errors++; $display("FAIL bp_once got send=%b want 0", out_send); end
      checks++; if (sent_count !== cnt0 + 16'd1) begin errors++; $display("FAIL bp_count got %0d want %0d", sent_count, cnt0 + 16'd1); end
      tick();
   endtask

   task automatic test_bad_grant();
      polarity = 1'b0; out_ready = 1'b0; en = 1'b1; gnt = 5'b00011;
      #2;
      checks++; if (in_ack !== 5'd0) begin errors++; $display("FAIL bad_ack got %b want 00000", in_ack); end
      tick();
      #2;
      checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", gnt_err); end
      checks++; if (output_empty !== 1'b1) begin errors++; $display("FAIL bad_nocap got %b want 1", output_empty); end
      gnt = 5'b00100;
      #2;
      checks++; if (in_ack !== 5'b00100) begin errors++; $display("FAIL bad_next_ack got %b want 00100", in_ack); end
      tick();
      #2;
      checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", gnt_err); end
      do_reset();
      #2;
      checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL bad_reset got %b want 0", gnt_err); end
   endtask

   // Grants every cycle with ready high: one flit per cycle, in order.
   task automatic stream(input int n, output int sent, output int left);
      logic [DW-1:0] q[$];
      logic [4:0] g;
      int idx;
      sent = 0;
      out_ready = 1'b1; en = 1'b1;
      for (int c = 0; c <= n; c++) begin
         polarity = c[0];
         rand_data();
         idx = $urandom_range(0, 4);
         g = 5'd1 << idx;
         gnt = (c < n) ? g : 5'd0;
         #2;
         if (c < n) begin
            checks++; if (in_ack !== g) begin errors++; $display("FAIL stream_ack c=%0d got %b want %b", c, in_ack, g); end
         end
         if (c > 0) begin
            checks++;
            if (out_send !== 1'b1 || q.size() == 0 || out_data !== q[0]) begin
               errors++; $display("FAIL stream_data c=%0d got send=%b data=%h want %h", c, out_send, out_data, (q.size() > 0) ? q[0] : 64'd0);
            end
            if (q.size() > 0) void'(q.pop_front());
            sent++;
         end
         if (c < n) q.push_back(in_data[idx*DW +: DW]);
         tick();
      end
      gnt = 5'd0; out_ready = 1'b0;
      left = q.size();
   endtask

   task automatic test_simultaneous();
      int sent, left;
      logic [15:0] cnt0;
      cnt0 = sent_count;
      stream(22, sent, left);
      checks++; if (left != 0 || sent != 22) begin errors++; $display("FAIL sim_count got sent=%0d left=%0d want 22/0", sent, left); end
      checks++; if (sent_count !== cnt0 + 16'd22) begin errors++; $display("FAIL sim_link got %0d want %0d", sent_count, cnt0 + 16'd22); end
   endtask

   task automatic test_saturation();
      int sent, left;
      do_reset();
      stream(20, sent, left);
      #2;
      checks++; if (s_sent_count !== 4'hF) begin errors++; $display("FAIL sat_count got %h want f", s_sent_count); end
      checks++; if (sent_count !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d want 20", sent_count); end
   endtask

   task automatic test_random();
      int p, r;
      logic [4:0] e_ack;
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 9) < 8) polarity = ~polarity;
         en = ($urandom_range(0, 9) < 9);
         out_ready = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 19);
         if (r == 0) gnt = 5'd0;
         else if (r == 1) gnt = 5'b10001 | (5'd1 << $urandom_range(1, 3));
         else gnt = 5'd1 << $urandom_range(0, 4);
         rand_data();
         #2;
         p = int'(polarity);
         e_ack = (en && !m_full[p] && $countones(gnt) == 1) ? gnt : 5'd0;
         checks++; if (output_empty !== !m_full[p]) begin errors++; $display("FAIL rnd_empty c=%0d got %b want %b", c, output_empty, !m_full[p]); end
         checks++; if (in_ack !== e_ack) begin errors++; $display("FAIL rnd_ack c=%0d got %b want %b", c, in_ack, e_ack); end
         checks++; if (out_send !== m_full[1-p]) begin errors++; $display("FAIL rnd_send c=%0d got %b want %b", c, out_send, m_full[1-p]); end
         checks++; if (out_data !== m_data[1-p]) begin errors++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, m_data[1-p]); end
         checks++; if (sent_count !== 16'(m_count)) begin errors++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, sent_count, m_count); end
         checks++; if (s_sent_count !== ((m_count > 15) ? 4'hF : 4'(m_count))) begin errors++; $display("FAIL rnd_sat c=%0d got %0d want %0d", c, s_sent_count, (m_count > 15) ? 15 : m_count); end
         checks++; if (gnt_err !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got %b want %b", c, gnt_err, m_err); end
         tick();
      end
   endtask

   initial begin
      reset = 1'b0; polarity = 1'b0; en = 1'b0; gnt = 5'd0;
      in_data = '0; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_bad_grant();
      test_simultaneous();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
